// File: rtl/mult_operand_feeder_pkg.sv
// mult_operand_feeder_pkg
//   Constants and helpers shared by the operand feeder, its FIFO and its
//   interface.
//   CYC_W     : width of the RUN-state cycle counter; this matches the
//               multiplier's 6-bit iteration counter, hence WIDTH <= 61.
//   cnt_width : width of an occupancy count able to hold 0..depth.
package mult_operand_feeder_pkg;

  localparam int CYC_W = 6;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_operand_feeder_if.sv
// mult_operand_feeder_if
//   Bundles the operand stream, result stream, multiplier drive and status
//   signals of the operand feeder.
//   Operand stream : in_valid, in_ready, in_a, in_b
//   Result stream  : out_valid, out_ready, out_p
//   Multiplier     : mul_start, mul_a, mul_b (to multiplier), mul_o (from it)
//   Status         : fifo_count, busy
//   modport slave  : the feeder's view
//   modport master : the environment's view (producer, consumer, multiplier)
interface mult_operand_feeder_if
  import mult_operand_feeder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_a;
  logic [WIDTH-1:0]              in_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [2*WIDTH-1:0]            out_p;
  logic                          mul_start;
  logic [WIDTH-1:0]              mul_a;
  logic [WIDTH-1:0]              mul_b;
  logic [2*WIDTH-1:0]            mul_o;
  logic [cnt_width(DEPTH)-1:0]   fifo_count;
  logic                          busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_o,
    output in_ready, out_valid, out_p, mul_start, mul_a, mul_b, fifo_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_o,
    input  in_ready, out_valid, out_p, mul_start, mul_a, mul_b, fifo_count, busy
  );

endinterface

// File: rtl/mult_operand_feeder_fifo.sv
// operand_fifo
//   Synchronous FIFO holding packed operand pairs for the feeder.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write an entry (caller guarantees not full unless popping)
//   pop/dout : dout is the head entry; pop advances past it
//   count    : number of stored entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module operand_fifo
  import mult_operand_feeder_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DW-1:0]               din,
  input  logic                        pop,
  output logic [DW-1:0]               dout,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder
//   Queues operand pairs, feeds them one at a time to a sequential shift-add
//   multiplier through its level-sensitive start/A/B protocol, and presents
//   each product on a valid/ready result stream with backpressure.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_operand_feeder_if.slave (operand stream, result stream,
//          multiplier drive/return, fifo_count, busy)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | start low; pop the FIFO head when one is queued
//   RUN     | start high; count cycles until the product is settled
//   HOLD    | start high to keep the product stable until it can be taken
//   RECOVER | start low for one cycle so the multiplier clears itself
module mult_operand_feeder
  import mult_operand_feeder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_operand_feeder_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  // Last RUN cycle; the capture happens on the edge that ends it.
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIDTH + 2);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [CYC_W-1:0]   cyc_q;
  logic               pop;
  logic               push;
  logic               capture;
  logic               capture_ok;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [2*WIDTH-1:0] out_p_q;
  logic               out_valid_q;
  logic               mul_start;
  logic               busy;

  // in_ready is derived from the registered count only, never from pop.
  assign push = bus.in_valid && !full;

  operand_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // The result register can take a new product when it is empty or is
  // being drained on this very edge.
  assign capture_ok = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cyc_q == CYC_LAST) begin
          if (capture_ok) begin
            capture = 1'b1;
            state_d = S_RECOVER;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (capture_ok) begin
          capture = 1'b1;
          state_d = S_RECOVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state_q == S_RUN) || (state_q == S_HOLD);
    busy      = (state_q != S_IDLE) || (count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (pop) begin
        cyc_q   <= '0;
        mul_a_q <= head[2*WIDTH-1:WIDTH];
        mul_b_q <= head[WIDTH-1:0];
      end else if (state_q == S_RUN) begin
        cyc_q <= cyc_q + 1'b1;
      end
      // A capture on the same edge as a handshake keeps out_valid high.
      if (capture) begin
        out_p_q     <= bus.mul_o;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_p      = out_p_q;
  assign bus.mul_start  = mul_start;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.fifo_count = count;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// tb_mult_operand_feeder
//   Integration bench: operand feeder plus a behavioural shift-add
//   multiplier (product settles WIDTH+1 edges after start rises, cleared
//   whenever start is low). Expected products are plain a*b.
module tb_mult_operand_feeder;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_operand_feeder_if #(.WIDTH(W), .DEPTH(D)) bus ();

  mult_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int max_cnt = 0;
  int gbase = 0;
  int ebase = 0;

  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_p [$];
  int            got_e [$];

  logic [PW-1:0] m_o;
  int            m_n;
  assign bus.mul_o = m_o;

  // Multiplier model, edge counter and result-stream monitor.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!bus.mul_start) begin
      m_n <= 0;
      m_o <= '0;
    end else if (m_n < W) begin
      m_n <= m_n + 1;
    end else begin
      m_o <= PW'(bus.mul_a) * PW'(bus.mul_b);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_p.push_back(bus.out_p);
      got_e.push_back(edge_n + 1);
    end
  end

  always @(negedge clk) begin
    if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int   budget = 200;
    logic acc;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    do begin
      acc = bus.in_ready;
      @(negedge clk);
      budget--;
    end while (!acc && budget > 0);
    if (acc) exp_q.push_back(PW'(a) * PW'(b));
    else     check("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain_check(input string tag, input int n);
    int budget = 2000;
    while (got_p.size() < gbase + n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_count"}, 64'(got_p.size() - gbase), 64'(n));
    for (int i = 0; i < n && gbase + i < got_p.size(); i++)
      check(tag, 64'(got_p[gbase + i]), 64'(exp_q[ebase + i]));
    gbase += n;
    ebase += n;
  endtask

  initial begin
    int   pe;
    int   ms;
    int   rise;
    int   s;
    int   budget;
    int   npush;
    logic acc;
    logic [PW-1:0] pv;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_in_ready",   64'(bus.in_ready),   64'd1);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_p",      64'(bus.out_p),      64'd0);
    check("rst_mul_start",  64'(bus.mul_start),  64'd0);
    check("rst_mul_a",      64'(bus.mul_a),      64'd0);
    check("rst_mul_b",      64'(bus.mul_b),      64'd0);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_busy",       64'(bus.busy),       64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single operation latency and start window.
    bus.out_ready = 1'b1;
    push(8'd3, 8'd5);
    bus.in_valid = 1'b0;
    pe = edge_n;
    ms = 0;
    rise = -1;
    pv = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mul_start) ms++;
      if (bus.out_valid && rise < 0) begin
        rise = edge_n - pe;
        pv   = bus.out_p;
      end
    end
    check("t1_latency",    64'(rise), 64'd12);
    check("t1_start_len",  64'(ms),   64'd11);
    check("t1_product",    64'(pv),   64'd15);
    drain_check("t1", 1);

    // Back-to-back queue, products in order 13 cycles apart.
    s = got_p.size();
    push(8'd255, 8'd255);
    push(8'd0,   8'd77);
    push(8'd1,   8'd200);
    push(8'd16,  8'd16);
    bus.in_valid = 1'b0;
    drain_check("t2", 4);
    check("t2_p0", 64'(exp_q[ebase - 4]), 64'd65025);
    for (int i = 1; i < 4 && s + i < got_e.size(); i++)
      check("t2_spacing", 64'(got_e[s + i] - got_e[s + i - 1]), 64'd13);

    // Backpressure: fill, hold, then drain.
    bus.out_ready = 1'b0;
    push(8'd10, 8'd20);
    push(8'd30, 8'd40);
    push(8'd50, 8'd60);
    push(8'd70, 8'd80);
    push(8'd90, 8'd100);
    bus.in_valid = 1'b0;
    check("t3_full_count", 64'(bus.fifo_count), 64'd4);
    check("t3_full_ready", 64'(bus.in_ready),   64'd0);
    repeat (40) @(negedge clk);
    check("t3_hold_start", 64'(bus.mul_start),  64'd1);
    check("t3_hold_valid", 64'(bus.out_valid),  64'd1);
    check("t3_hold_p",     64'(bus.out_p),      64'd200);
    check("t3_hold_a",     64'(bus.mul_a),      64'd30);
    check("t3_hold_b",     64'(bus.mul_b),      64'd40);
    check("t3_hold_count", 64'(bus.fifo_count), 64'd3);
    repeat (5) @(negedge clk);
    check("t3_hold_p2",    64'(bus.out_p),      64'd200);
    check("t3_hold_start2",64'(bus.mul_start),  64'd1);
    bus.out_ready = 1'b1;
    drain_check("t3", 5);

    // Capture in the same cycle as the handshake.
    bus.out_ready = 1'b0;
    push(8'd12, 8'd12);
    push(8'd13, 8'd14);
    bus.in_valid = 1'b0;
    budget = 100;
    while (!bus.out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t4_first_valid", 64'(bus.out_valid), 64'd1);
    repeat (20) @(negedge clk);
    check("t4_no_hs_yet", 64'(got_p.size() - gbase), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_one_hs",     64'(got_p.size() - gbase), 64'd1);
    check("t4_valid_kept", 64'(bus.out_valid),        64'd1);
    check("t4_second_p",   64'(bus.out_p),            64'd182);
    bus.out_ready = 1'b1;
    drain_check("t4", 2);

    // Reset in the middle of RUN (cyc=4) with pairs queued.
    push(8'd11, 8'd13);
    pe = edge_n;
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_running", 64'(edge_n - pe), 64'd5);
    check("t5_start_hi", 64'(bus.mul_start), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_start_lo",  64'(bus.mul_start),  64'd0);
    check("t5_valid_lo",  64'(bus.out_valid),  64'd0);
    check("t5_count_0",   64'(bus.fifo_count), 64'd0);
    check("t5_busy_0",    64'(bus.busy),       64'd0);
    rst = 1'b0;
    gbase = got_p.size();
    ebase = exp_q.size();
    @(negedge clk);
    push(8'd7, 8'd9);
    bus.in_valid = 1'b0;
    drain_check("t5", 1);
    repeat (30) @(negedge clk);
    check("t5_no_stale", 64'(got_p.size() - gbase), 64'd0);

    // Push held against a full FIFO while a pop happens.
    max_cnt = 0;
    bus.out_ready = 1'b1;
    push(8'd21, 8'd22);
    pe = edge_n;
    push(8'd23, 8'd24);
    push(8'd25, 8'd26);
    push(8'd27, 8'd28);
    push(8'd29, 8'd30);
    check("t6_full_count", 64'(bus.fifo_count), 64'd4);
    check("t6_full_ready", 64'(bus.in_ready),   64'd0);
    push(8'd31, 8'd32);
    check("t6_accept_edge", 64'(edge_n - pe), 64'd15);
    bus.in_valid = 1'b0;
    check("t6_count_after", 64'(bus.fifo_count), 64'd4);
    drain_check("t6", 6);
    check("t6_max_le4", 64'(max_cnt <= 4), 64'd1);

    // Randomized traffic with random backpressure.
    npush = 0;
    budget = 3000;
    while (npush < 12 && budget > 0) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_a     = W'($urandom());
        bus.in_b     = W'($urandom());
        bus.in_valid = 1'b1;
      end
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      budget--;
      if (acc) begin
        exp_q.push_back(PW'(bus.in_a) * PW'(bus.in_b));
        npush++;
        bus.in_valid = 1'b0;
      end
    end
    check("rand_pushed", 64'(npush), 64'd12);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain_check("rand", npush);
    repeat (5) @(negedge clk);
    check("end_idle", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
